seq_shift_add_multiplier: RTL and testbench
===========================================

Name: seq_shift_add_multiplier

Overview:
Parametrised sequential unsigned multiplier using the shift-and-add method. Each cycle it performs one conditional add of the multiplicand into the upper half of a 2*WIDTH accumulator using a WIDTH-bit ripple-carry adder, then shifts the accumulator right by one. It generalises the fixed 4-bit ripple adder and single D flip-flop into a WIDTH-bit multi-cycle datapath with a start/done handshake and a small controller FSM. It sits beside the arithmetic primitives as the first multi-cycle arithmetic unit.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..16.
CNT_W, derived = ceil(log2(WIDTH+1)), width of the iteration counter; not overridden.

Ports:
clk  input  1  rising-edge clock
clear  input  1  reset; asynchronous, active-high; forces every register to its reset value immediately
start  input  1  request to begin a multiply; sampled only in IDLE or DONE
a  input  WIDTH  multiplicand; captured on the edge that accepts start
b  input  WIDTH  multiplier; captured on the edge that accepts start
product  output  2*WIDTH  registered result of the last completed multiply
busy  output  1  high while iterations are in progress (RUN state)
done  output  1  single-cycle pulse; product is valid and newly updated

Behaviour:
- Reset (clear=1, any time, asynchronous): state=IDLE, multiplicand, accumulator, counter and product all 0, busy=0, done=0. Clearing mid-RUN aborts the operation with no done pulse and product=0.
- Internal state: mcand[WIDTH]; acc[2*WIDTH+1], where the extra MSB holds the adder carry; cnt[CNT_W].
- FSM states: IDLE, RUN, DONE. busy=1 only in RUN. done=1 only in DONE. Both outputs are decoded from registered state, so they are glitch-free.
- IDLE: if start=1 at an edge, then mcand<=a, acc<={0, WIDTH zeros, b}, cnt<=0, and the next state is RUN. Otherwise stay in IDLE.
- RUN, one iteration per edge:
  - If acc[0]=1, the upper sum is acc[2W-1:W]+mcand with a full carry-out. Otherwise the upper sum is acc[2W-1:W] with carry 0.
  - Then acc<={0, carry, sum, acc[W-1:1]}, which is a logical right shift of {carry, sum, lower}.
  - cnt<=cnt+1.
  - When the iteration completing cnt=WIDTH-1 occurs, the next state is DONE and product<=the shifted result's low 2*WIDTH bits on that same edge.
- Latency: start is accepted at edge E0. Iterations run at E1..EW. product updates and done=1 after EW. Total latency is WIDTH+1 edges from the accepting edge to done high.
- DONE lasts exactly one cycle. If start=1 in DONE, a new operation is accepted (same actions as in IDLE) and the next state is RUN, giving back-to-back throughput of one result per WIDTH+1 cycles. Otherwise the next state is IDLE.
- start during RUN is ignored. a and b may change freely during RUN without effect.
- product holds its value from the last completion until the next completion or clear. It never shows partial results.
- Arithmetic is unsigned. The result is exact for all inputs: the maximum (2^W-1)^2 fits in 2*WIDTH bits. The carry bit guarantees no overflow in the upper sum.
- b=0 or a=0 still takes the full WIDTH iterations. There is no early termination.

Test Plan:
- WIDTH=4: clear pulse, then a=15, b=15, start for 1 cycle -> busy=1 for 4 cycles, then done=1 for 1 cycle with product=225 (0xE1), then busy=0 and done=0.
- WIDTH=4: a=0, b=9 and a=7, b=0 -> product=0 each time, with full latency of 5 edges and done pulsing once each.
- WIDTH=4: a=13, b=11, start held high continuously -> products 143, then repeated 143, with done pulsing every 5 cycles and no idle gap. Changing a/b during RUN does not alter the result.
- WIDTH=4: start a=6, b=5, assert clear asynchronously between edges during the 2nd iteration -> busy, done and product go 0 immediately without waiting for clk. After release, a new start with a=6, b=5 gives product=30.
- WIDTH=4: start a=3, b=4, pulse start again at E2 -> the second start is ignored, exactly one done pulse, product=12.
- WIDTH=8: a=255, b=255 -> product=65025 after 9 edges. Also run 200 random operand pairs against a reference multiply and check for an exact match.

Source files
------------

// File: rtl/seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// seq_shift_add_multiplier
//
// Sequential unsigned multiplier using the shift-and-add method. Each RUN
// cycle conditionally adds the multiplicand into the upper half of a
// 2*WIDTH accumulator with a WIDTH-bit ripple-carry adder, then shifts the
// accumulator (with the adder carry on top) right by one bit. After WIDTH
// iterations the low 2*WIDTH bits hold the exact product.
//
// Ports:
//   clk      in   1         rising-edge clock
//   clear    in   1         asynchronous active-high reset of every register
//   start    in   1         begin a multiply (accepted in IDLE or DONE only)
//   a        in   WIDTH     multiplicand, captured on the accepting edge
//   b        in   WIDTH     multiplier, captured on the accepting edge
//   product  out  2*WIDTH   result of the last completed multiply
//   busy     out  1         high while iterating (RUN)
//   done     out  1         one-cycle pulse when product has just updated
//
// Latency: WIDTH+1 edges from the accepting edge to done high. With start
// held, a new operation is accepted in DONE, giving one result every
// WIDTH+1 cycles.
// ---------------------------------------------------------------------------
module seq_shift_add_multiplier #(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   mcand;
    // Extra MSB reserves room for the adder carry before the shift.
    logic [2*WIDTH:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH:0]     carry;
    logic [2*WIDTH:0]   acc_shifted;
    logic               accept;
    logic               last_iter;

    // After every shift the top bit is zero, so it is never consumed.
    logic               acc_msb_unused;
    assign acc_msb_unused = acc[2*WIDTH];

    // Ripple-carry adder: upper accumulator half plus the multiplicand when
    // the current multiplier bit (acc[0]) is set, otherwise plus zero.
    always_comb begin
        addend = acc[0] ? mcand : '0;
        carry  = '0;
        sum    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = acc[WIDTH+i] ^ addend[i] ^ carry[i];
            carry[i+1] = (acc[WIDTH+i] & addend[i])
                       | (carry[i] & (acc[WIDTH+i] ^ addend[i]));
        end
    end

    // Logical right shift of {carry, sum, lower half}; the consumed
    // multiplier bit acc[0] drops off the bottom.
    assign acc_shifted = {1'b0, carry[WIDTH], sum, acc[WIDTH-1:1]};
    assign last_iter   = (cnt == CNT_W'(WIDTH - 1));
    assign accept      = start && (state != RUN);

    // State register
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and decoded outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            mcand   <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            mcand <= a;
            acc   <= {{(WIDTH+1){1'b0}}, b};
            cnt   <= '0;
        end else if (state == RUN) begin
            acc <= acc_shifted;
            cnt <= cnt + 1'b1;
            // Only the final iteration publishes, so product never shows
            // a partial sum.
            if (last_iter) begin
                product <= acc_shifted[2*WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_add_multiplier
//
// Bench for seq_shift_add_multiplier at WIDTH=4 and WIDTH=8. Expected
// products come from plain multiplication; timing expectations come from
// the documented latency (WIDTH+1 edges inclusive of the accepting edge).
// ---------------------------------------------------------------------------
module tb_seq_shift_add_multiplier;

    logic        clk;
    logic        clear;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic [7:0]  p4;
    logic        busy4;
    logic        done4;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [15:0] p8;
    logic        busy8;
    logic        done8;

    int total;
    int bad;

    // Reference model of the last completed product for each instance.
    logic [15:0] prod_m4;
    logic [15:0] prod_m8;

    seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .clear   (clear),
        .start   (start4),
        .a       (a4),
        .b       (b4),
        .product (p4),
        .busy    (busy4),
        .done    (done4)
    );

    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .clear   (clear),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .product (p8),
        .busy    (busy8),
        .done    (done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic get_done(input bit w8);
        return w8 ? done8 : done4;
    endfunction

    function automatic logic get_busy(input bit w8);
        return w8 ? busy8 : busy4;
    endfunction

    function automatic logic [15:0] get_prod(input bit w8);
        return w8 ? p8 : {8'd0, p4};
    endfunction

    function automatic logic [15:0] get_model(input bit w8);
        return w8 ? prod_m8 : prod_m4;
    endfunction

    task automatic set_ab(input bit w8, input logic [7:0] x, input logic [7:0] y);
        if (w8) begin
            a8 = x;
            b8 = y;
        end else begin
            a4 = x[3:0];
            b4 = y[3:0];
        end
    endtask

    task automatic set_start(input bit w8, input logic s);
        if (w8) start8 = s;
        else    start4 = s;
    endtask

    // One complete operation: start for one edge, then watch until done.
    // scramble: randomise a/b while iterating. restart_at: raise start so it
    // is high at that edge number after the accepting edge (0 = never).
    task automatic do_op(input bit w8, input logic [7:0] x, input logic [7:0] y,
                         input bit scramble, input int restart_at, input string tag);
        int          n;
        int          busy_n;
        int          wid;
        logic [15:0] expv;
        wid  = w8 ? 8 : 4;
        expv = w8 ? ({8'd0, x} * {8'd0, y})
                  : ({12'd0, x[3:0]} * {12'd0, y[3:0]});
        set_ab(w8, x, y);
        set_start(w8, 1'b1);
        @(posedge clk); #1;
        set_start(w8, 1'b0);
        n      = 0;
        busy_n = 0;
        while (!get_done(w8) && n < 3 * wid) begin
            if (get_busy(w8)) busy_n++;
            chk({tag, "_hold"}, 32'(get_prod(w8)), 32'(get_model(w8)));
            if (scramble) set_ab(w8, 8'($urandom), 8'($urandom));
            set_start(w8, (restart_at != 0) && (n + 1 == restart_at));
            @(posedge clk); #1;
            n++;
        end
        set_start(w8, 1'b0);
        chk({tag, "_latency"}, 32'(n), 32'(wid));
        chk({tag, "_busycycles"}, 32'(busy_n), 32'(wid));
        chk({tag, "_done"}, 32'(get_done(w8)), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(get_busy(w8)), 32'd0);
        chk({tag, "_product"}, 32'(get_prod(w8)), 32'(expv));
        if (w8) prod_m8 = expv;
        else    prod_m4 = expv;
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(get_done(w8)), 32'd0);
        chk({tag, "_idle_busy"}, 32'(get_busy(w8)), 32'd0);
        chk({tag, "_product_held"}, 32'(get_prod(w8)), 32'(expv));
    endtask

    initial begin
        int n;
        int exp_n;
        total   = 0;
        bad     = 0;
        prod_m4 = '0;
        prod_m8 = '0;
        start4  = 1'b0;
        start8  = 1'b0;
        a4      = '0;
        b4      = '0;
        a8      = '0;
        b8      = '0;

        // Reset takes effect before any clock edge
        clear = 1'b1;
        #2;
        chk("rst_busy4", 32'(busy4), 32'd0);
        chk("rst_done4", 32'(done4), 32'd0);
        chk("rst_prod4", 32'(p4), 32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_prod8", 32'(p8), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b0;

        do_op(1'b0, 8'd15, 8'd15, 1'b0, 0, "w4_15x15");
        do_op(1'b0, 8'd0,  8'd9,  1'b0, 0, "w4_0x9");
        do_op(1'b0, 8'd7,  8'd0,  1'b0, 0, "w4_7x0");
        do_op(1'b0, 8'd3,  8'd4,  1'b0, 2, "w4_restart_ignored");
        do_op(1'b0, 8'd13, 8'd11, 1'b1, 0, "w4_scramble");

        // Back-to-back with start held high; a/b wander during RUN and are
        // restored only for the DONE-state accepting edge.
        a4 = 4'd13;
        b4 = 4'd11;
        start4 = 1'b1;
        @(posedge clk); #1;
        n = 0;
        for (int r = 0; r < 3; r++) begin
            exp_n = (r == 0) ? 4 : 5;
            while (!done4 && n < 20) begin
                a4 = 4'($urandom);
                b4 = 4'($urandom);
                @(posedge clk); #1;
                n++;
            end
            chk("b2b_period", 32'(n), 32'(exp_n));
            chk("b2b_product", 32'(p4), 32'd143);
            prod_m4 = 16'd143;
            a4 = 4'd13;
            b4 = 4'd11;
            if (r == 2) start4 = 1'b0;
            @(posedge clk); #1;
            n = 1;
            chk("b2b_busy_next", 32'(busy4), (r == 2) ? 32'd0 : 32'd1);
            chk("b2b_done_once", 32'(done4), 32'd0);
        end

        // Asynchronous clear in the middle of the second iteration
        a4 = 4'd6;
        b4 = 4'd5;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        chk("clr_busy_before", 32'(busy4), 32'd1);
        #2;
        clear = 1'b1;
        #1;
        chk("clr_busy", 32'(busy4), 32'd0);
        chk("clr_done", 32'(done4), 32'd0);
        chk("clr_prod", 32'(p4), 32'd0);
        chk("clr_prod8", 32'(p8), 32'd0);
        clear = 1'b0;
        prod_m4 = '0;
        prod_m8 = '0;
        do_op(1'b0, 8'd6, 8'd5, 1'b0, 0, "w4_after_clear");

        do_op(1'b1, 8'd255, 8'd255, 1'b0, 0, "w8_max");
        do_op(1'b1, 8'd0,   8'd255, 1'b0, 0, "w8_zero");

        for (int k = 0; k < 200; k++) begin
            do_op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 0, "w8_rand");
        end
        for (int k = 0; k < 40; k++) begin
            do_op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 0, "w4_rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
